// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the MEM-stage controller: FSM encoding, pipeline record
// captured from EX/MEM, and the registered writeback bundle.
package mem_stage_ctrl_pkg;

   localparam int TIMEOUT_DEFAULT = 255;
   localparam int CNT_W           = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mem_state_e;

   // Everything about one instruction that must survive a multi-cycle access.
   typedef struct packed {
      logic [15:0] xout;
      logic [15:0] pc_plus_two;
      logic        link;
      logic        mem_to_reg;
      logic [2:0]  wreg;
      logic        reg_write;
      logic        halt;
      logic        createdump;
      logic        err;
   } ex_mem_t;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  wreg;
      logic        reg_write;
      logic        halt;
      logic        createdump;
      logic        err;
   } wb_out_t;

   // Writeback source priority: link, then loaded data, then ALU result.
   function automatic wb_out_t to_wb(input ex_mem_t instr, input logic [15:0] rdata);
      wb_out_t wb;
      wb.data       = instr.link       ? instr.pc_plus_two :
                      instr.mem_to_reg ? rdata             : instr.xout;
      wb.wreg       = instr.wreg;
      wb.reg_write  = instr.reg_write;
      wb.halt       = instr.halt;
      wb.createdump = instr.createdump;
      wb.err        = instr.err;
      return wb;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait counter for an outstanding memory access; tc flags the last allowed
// ACCESS cycle so the controller gives up on the following edge.
module mem_timeout_ctr
   import mem_stage_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = en & (cnt_q == TC_VALUE);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues single outstanding memory accesses, stalls the
// pipeline while they are in flight, and registers the writeback bundle.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] XOut_in,
   input  logic [15:0] read2Data_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic [15:0] PC_plus_two_in,
   input  logic        link_in,
   input  logic        MemtoReg_in,
   input  logic [2:0]  Write_register_in,
   input  logic        RegWrite_in,
   input  logic        halt_in,
   input  logic        createdump_in,
   input  logic        err_in,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done,
   output logic        DC_Stall,
   output logic [15:0] wb_data,
   output logic [2:0]  Write_register_out,
   output logic        RegWrite_out,
   output logic        halt_out,
   output logic        createdump_out,
   output logic        err_out
);

   mem_state_e  state_q, state_d;
   ex_mem_t     req_q, req_d;
   logic        req_wr_q, req_wr_d;
   logic [15:0] req_addr_q, req_addr_d;
   logic [15:0] req_wdata_q, req_wdata_d;
   logic [15:0] rdata_q, rdata_d;
   wb_out_t     wb_q, wb_d;
   logic        halted_q, halted_d;

   ex_mem_t     in_instr;
   logic        mem_any;
   logic        local_err;
   logic        start;
   logic        in_access;
   logic        wait_tc;

   // Conflicting or unaligned requests never reach memory; they retire as errors.
   assign mem_any   = MemRead_in | MemWrite_in;
   assign local_err = (MemRead_in & MemWrite_in) | (mem_any & XOut_in[0]);
   assign start     = (state_q == ST_IDLE) && (MemRead_in ^ MemWrite_in) &&
                      !XOut_in[0] && !halted_q;
   assign in_access = (state_q == ST_ACCESS);

   always_comb begin
      in_instr.xout        = XOut_in;
      in_instr.pc_plus_two = PC_plus_two_in;
      in_instr.link        = link_in;
      in_instr.mem_to_reg  = MemtoReg_in;
      in_instr.wreg        = Write_register_in;
      in_instr.reg_write   = RegWrite_in & ~local_err;
      in_instr.halt        = halt_in;
      in_instr.createdump  = createdump_in;
      in_instr.err         = err_in | local_err;
   end

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk (clk),
      .rst (rst),
      .clr (~in_access),
      .en  (in_access),
      .tc  (wait_tc)
   );

   // The request leaves combinationally in its first cycle, so it is gated by
   // rst to go quiet the moment reset asserts, not just at the next edge.
   assign mem_en    = rst & (start | in_access);
   assign DC_Stall  = mem_en;
   assign mem_wr    = in_access ? req_wr_q    : MemWrite_in;
   assign mem_addr  = in_access ? req_addr_q  : XOut_in;
   assign mem_wdata = in_access ? req_wdata_q : read2Data_in;

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      req_wr_d    = req_wr_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      rdata_d     = rdata_q;
      wb_d        = wb_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_ACCESS;
               req_d       = in_instr;
               req_wr_d    = MemWrite_in;
               req_addr_d  = XOut_in;
               req_wdata_d = read2Data_in;
               wb_d        = '0;
            end else begin
               wb_d = to_wb(in_instr, rdata_q);
            end
         end
         ST_ACCESS: begin
            if (mem_done) begin
               state_d = ST_DONE;
               rdata_d = mem_rdata;
               wb_d    = to_wb(req_q, mem_rdata);
            end else if (wait_tc) begin
               state_d        = ST_DONE;
               wb_d           = to_wb(req_q, rdata_q);
               wb_d.err       = 1'b1;
               wb_d.reg_write = 1'b0;
            end
         end
         ST_DONE: begin
            // The frozen EX/MEM entry was already retired; let WB see a bubble.
            state_d = ST_IDLE;
            wb_d    = '0;
         end
         default: begin
            state_d = ST_IDLE;
            wb_d    = '0;
         end
      endcase

      halted_d = halted_q | wb_d.halt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         req_wr_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         rdata_q     <= '0;
         wb_q        <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         req_wr_q    <= req_wr_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         rdata_q     <= rdata_d;
         wb_q        <= wb_d;
         halted_q    <= halted_d;
      end
   end

   assign wb_data            = wb_q.data;
   assign Write_register_out = wb_q.wreg;
   assign RegWrite_out       = wb_q.reg_write;
   assign halt_out           = wb_q.halt;
   assign createdump_out     = wb_q.createdump;
   assign err_out            = wb_q.err;

endmodule
